// File: rtl/demux_pkg.sv
// Shared definitions for the three-channel demux: default width, channel count,
// error-counter ceiling and the per-channel buffer state encoding.
package demux_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int NUM_CH    = 3;
  localparam int ERR_MAX   = 255;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_t;

  // Saturating increment so the illegal-select counter sticks at its ceiling.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'(ERR_MAX)) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/demux_chan.sv
// One-entry output buffer for a single demux channel; refills in the same cycle
// it is drained so a streaming consumer sees no bubble.
module demux_chan
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             ready,
  output ch_state_t        state,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  ch_state_t next_state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= CH_EMPTY;
    else       state <= next_state;
  end

  // A simultaneous drain and load keeps the buffer full with the new word.
  always_comb begin
    next_state = state;
    case (state)
      CH_EMPTY: if (load)           next_state = CH_FULL;
      CH_FULL:  if (ready && !load) next_state = CH_EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     q <= '0;
    else if (load) q <= data;
  end

  assign valid = (state == CH_FULL);

endmodule

// File: rtl/demux.sv
// Three-way valid/ready demultiplexer: routes ip to the one-hot selected channel
// buffer and drops illegal selects, flagging each with err and a saturating count.
module demux
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] ip,
  input  logic             in_valid,
  input  logic             sel1,
  input  logic             sel2,
  input  logic             sel3,
  output logic             in_ready,
  output logic [WIDTH-1:0] op1,
  output logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] op3,
  output logic             op1_valid,
  output logic             op2_valid,
  output logic             op3_valid,
  input  logic             op1_ready,
  input  logic             op2_ready,
  input  logic             op3_ready,
  output logic             err,
  output logic [7:0]       err_count
);

  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] ready;
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] valid;
  logic [WIDTH-1:0]  q [NUM_CH];
  ch_state_t         state [NUM_CH];
  logic              legal;
  logic              xfer;

  assign sel   = {sel3, sel2, sel1};
  assign ready = {op3_ready, op2_ready, op1_ready};

  // Exactly one bit set: odd parity excludes 000/011/101/110, and-reduce excludes 111.
  assign legal = (^sel) & ~(&sel);

  // Illegal selects are always accepted so they can be consumed and counted.
  assign in_ready = ~legal | (|(sel & accept));
  assign xfer     = in_valid & in_ready;
  assign load     = {NUM_CH{xfer & legal}} & sel;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
    assign accept[n] = (state[n] == CH_EMPTY) | ready[n];

    demux_chan #(.WIDTH(WIDTH)) u_chan (
      .clock (clock),
      .reset (reset),
      .load  (load[n]),
      .data  (ip),
      .ready (ready[n]),
      .state (state[n]),
      .q     (q[n]),
      .valid (valid[n])
    );
  end

  assign op1       = q[0];
  assign op2       = q[1];
  assign op3       = q[2];
  assign op1_valid = valid[0];
  assign op2_valid = valid[1];
  assign op3_valid = valid[2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err       <= 1'b0;
      err_count <= 8'd0;
    end else begin
      err <= xfer & ~legal;
      if (xfer && !legal) err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_demux.sv
// Self-checking bench for demux: a per-channel queue model predicts in_ready,
// channel contents, err and err_count, and is compared every cycle.
module tb_demux;

  logic       clock;
  logic       reset;
  logic [3:0] ip;
  logic       in_valid;
  logic [2:0] sel;
  logic [2:0] rdy;
  logic       in_ready;
  logic [3:0] op [3];
  logic [2:0] vld;
  logic       err;
  logic [7:0] err_count;

  logic [3:0] sbq [3][$];
  logic       exp_err;
  int         exp_cnt;
  int         vectors;
  int         miscompares;

  demux #(.WIDTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .ip        (ip),
    .in_valid  (in_valid),
    .sel1      (sel[0]),
    .sel2      (sel[1]),
    .sel3      (sel[2]),
    .in_ready  (in_ready),
    .op1       (op[0]),
    .op2       (op[1]),
    .op3       (op[2]),
    .op1_valid (vld[0]),
    .op2_valid (vld[1]),
    .op3_valid (vld[2]),
    .op1_ready (rdy[0]),
    .op2_ready (rdy[1]),
    .op3_ready (rdy[2]),
    .err       (err),
    .err_count (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clear_model();
    for (int n = 0; n < 3; n++) sbq[n].delete();
    exp_err = 1'b0;
    exp_cnt = 0;
  endtask

  // Called just after a falling edge with inputs set: check, update the model,
  // then advance one full clock.
  task automatic step();
    logic legal;
    logic exp_rdy;
    #1;
    legal   = $onehot(sel);
    exp_rdy = !legal;
    for (int n = 0; n < 3; n++)
      if (legal && sel[n] && (sbq[n].size() == 0 || rdy[n])) exp_rdy = 1'b1;
    vectors++;
    if (in_ready !== exp_rdy) begin
      miscompares++;
      $display("FAIL in_ready: got %b expected %b sel=%b t=%0t", in_ready, exp_rdy, sel, $time);
    end
    vectors++;
    if (err !== exp_err) begin
      miscompares++;
      $display("FAIL err: got %b expected %b t=%0t", err, exp_err, $time);
    end
    vectors++;
    if (err_count !== 8'(exp_cnt)) begin
      miscompares++;
      $display("FAIL err_count: got %0d expected %0d t=%0t", err_count, exp_cnt, $time);
    end
    for (int n = 0; n < 3; n++) begin
      vectors++;
      if (vld[n] !== (sbq[n].size() != 0)) begin
        miscompares++;
        $display("FAIL op%0d_valid: got %b expected %b t=%0t", n + 1, vld[n], sbq[n].size() != 0, $time);
      end
      if (sbq[n].size() != 0) begin
        vectors++;
        if (op[n] !== sbq[n][0]) begin
          miscompares++;
          $display("FAIL op%0d data: got %h expected %h t=%0t", n + 1, op[n], sbq[n][0], $time);
        end
        if (rdy[n]) void'(sbq[n].pop_front());
      end
    end
    if (in_valid && exp_rdy) begin
      if (legal) begin
        for (int n = 0; n < 3; n++) if (sel[n]) sbq[n].push_back(ip);
      end else if (exp_cnt < 255) begin
        exp_cnt++;
      end
    end
    exp_err = in_valid && exp_rdy && !legal;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [3:0] d);
    in_valid = v;
    sel      = s;
    ip       = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 3'b000, 4'h0);
    rdy = 3'b000;
    clear_model();
    #3;
    vectors++;
    if (vld !== 3'b000 || err !== 1'b0 || err_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b err=%b cnt=%0d expected 000/0/0", vld, err, err_count);
    end
    for (int n = 0; n < 3; n++) begin
      vectors++;
      if (op[n] !== 4'h0) begin
        miscompares++;
        $display("FAIL reset_op%0d: got %h expected 0", n + 1, op[n]);
      end
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_single();
    drive(1'b1, 3'b001, 4'b0001);
    step();
    drive(1'b0, 3'b000, 4'h0);
    #1;
    vectors++;
    if (op[0] !== 4'b0001 || vld !== 3'b001) begin
      miscompares++;
      $display("FAIL single_ch1: op1=%h valid=%b expected 1/001", op[0], vld);
    end
    step();
    rdy = 3'b001;
    step();
    rdy = 3'b000;
    step();
  endtask

  task automatic test_back_to_back();
    rdy = 3'b010;
    drive(1'b1, 3'b010, 4'b0010);
    step();
    drive(1'b1, 3'b010, 4'b0100);
    #1;
    vectors++;
    if (op[1] !== 4'b0010 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: op2=%h in_ready=%b expected 2/1", op[1], in_ready);
    end
    step();
    drive(1'b0, 3'b000, 4'h0);
    #1;
    vectors++;
    if (op[1] !== 4'b0100 || vld[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second: op2=%h valid=%b expected 4/1", op[1], vld[1]);
    end
    step();
    rdy = 3'b000;
    step();
  endtask

  task automatic test_backpressure();
    rdy = 3'b000;
    drive(1'b1, 3'b100, 4'h5);
    step();
    drive(1'b1, 3'b100, 4'h9);
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_stall: in_ready=%b expected 0", in_ready);
    end
    step();
    step();
    rdy = 3'b100;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || op[2] !== 4'h5) begin
      miscompares++;
      $display("FAIL bp_release: in_ready=%b op3=%h expected 1/5", in_ready, op[2]);
    end
    step();
    drive(1'b0, 3'b000, 4'h0);
    rdy = 3'b000;
    #1;
    vectors++;
    if (op[2] !== 4'h9 || vld[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_newword: op3=%h valid=%b expected 9/1", op[2], vld[2]);
    end
    step();
    rdy = 3'b100;
    step();
    rdy = 3'b000;
  endtask

  task automatic test_illegal();
    drive(1'b1, 3'b000, 4'h7);
    step();
    drive(1'b1, 3'b111, 4'h7);
    step();
    drive(1'b0, 3'b011, 4'h3);
    step();
    step();
    vectors++;
    if (err_count !== 8'd2 || vld !== 3'b000) begin
      miscompares++;
      $display("FAIL illegal: err_count=%0d valid=%b expected 2/000", err_count, vld);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'($urandom_range(0, 7)), 4'($urandom));
      step();
    end
  endtask

  task automatic test_independent();
    rdy = 3'b000;
    drive(1'b1, 3'b001, 4'hA);
    step();
    drive(1'b1, 3'b010, 4'hB);
    step();
    drive(1'b0, 3'b000, 4'h0);
    rdy = 3'b010;
    step();
    rdy = 3'b000;
    step();
    vectors++;
    if (vld !== 3'b001 || op[0] !== 4'hA) begin
      miscompares++;
      $display("FAIL independent: valid=%b op1=%h expected 001/A", vld, op[0]);
    end
    rdy = 3'b001;
    step();
    rdy = 3'b000;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, (i % 2 == 0) ? 3'b110 : 3'b000, 4'($urandom));
      step();
    end
    drive(1'b0, 3'b000, 4'h0);
    step();
    vectors++;
    if (err_count !== 8'd255) begin
      miscompares++;
      $display("FAIL saturate: err_count=%0d expected 255", err_count);
    end
    drive(1'b1, 3'b101, 4'h1);
    step();
    drive(1'b0, 3'b000, 4'h0);
    step();
  endtask

  task automatic test_reset_mid();
    rdy = 3'b000;
    drive(1'b1, 3'b001, 4'h3);
    step();
    drive(1'b1, 3'b010, 4'h6);
    step();
    drive(1'b1, 3'b100, 4'hC);
    step();
    drive(1'b1, 3'b011, 4'h0);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (vld !== 3'b000 || err_count !== 8'd0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: valid=%b cnt=%0d err=%b expected 000/0/0", vld, err_count, err);
    end
    for (int n = 0; n < 3; n++) begin
      vectors++;
      if (op[n] !== 4'h0) begin
        miscompares++;
        $display("FAIL reset_mid_op%0d: got %h expected 0", n + 1, op[n]);
      end
    end
    drive(1'b0, 3'b000, 4'h0);
    @(negedge clock);
    reset = 1'b0;
    clear_model();
    drive(1'b1, 3'b010, 4'hE);
    step();
    drive(1'b0, 3'b000, 4'h0);
    #1;
    vectors++;
    if (op[1] !== 4'hE || vld !== 3'b010) begin
      miscompares++;
      $display("FAIL resume: op2=%h valid=%b expected E/010", op[1], vld);
    end
    rdy = 3'b010;
    step();
    rdy = 3'b000;
    step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_independent();
    test_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/demux.md
DEMUX -- requirements
Module: demux

Interface
REQ-001 Parameter: WIDTH, 4, data width of the input and of each output channel.
REQ-002 Port: clock  input  1  single rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: ip  input  WIDTH  data word to route.
REQ-005 Port: in_valid  input  1  ip/sel qualified this cycle.
REQ-006 Port: sel1, sel2, sel3  input  1 each  one-hot channel select, sampled with in_valid.
REQ-007 Port: in_ready  output  1  demux accepts the offered word this cycle.
REQ-008 Port: op1, op2, op3  output  WIDTH each  per-channel registered data.
REQ-009 Port: op1_valid, op2_valid, op3_valid  output  1 each  channel N holds an undelivered word.
REQ-010 Port: op1_ready, op2_ready, op3_ready  input  1 each  consumer N takes opN this cycle.
REQ-011 Port: err  output  1  one-cycle pulse on a dropped illegal select.
REQ-012 Port: err_count  output  8  saturating count of illegal selects.

Function
REQ-013 Transfer SHALL occur on a rising clock edge when in_valid and in_ready are both high.
REQ-014 Select SHALL be legal only when exactly one of sel1/sel2/sel3 is high; 000, 011, 101, 110 and 111 are illegal.
REQ-015 in_ready SHALL be combinational: high when the select is illegal, or when the selected channel is EMPTY, or when it is FULL with its opN_ready high in the same cycle.
REQ-016 Each channel SHALL be a two-state machine: CH_EMPTY, CH_FULL.
REQ-017 CH_EMPTY -> CH_FULL on a transfer to that channel; opN loads ip; opN_valid high the next cycle (latency 1).
REQ-018 CH_FULL -> CH_EMPTY on opN_ready with no transfer to that channel.
REQ-019 CH_FULL with opN_ready and a transfer to that channel in the same cycle SHALL stay CH_FULL and load the new word, with no bubble.
REQ-020 CH_FULL without opN_ready SHALL hold opN stable; in_ready SHALL be low for a legal select of that channel.
REQ-021 opN SHALL retain its last value while CH_EMPTY; opN_ready while CH_EMPTY SHALL be ignored.
REQ-022 A transfer with an illegal select SHALL load no channel, assert err for exactly the next cycle, and increment err_count.
REQ-023 err_count SHALL saturate at 255 and never wrap.
REQ-024 With in_valid low, the select lines SHALL be ignored, with no error and no load.
REQ-025 Channels SHALL operate independently: draining one channel SHALL never affect another channel's state or data.

Reset
REQ-026 While reset is high, all channels SHALL be CH_EMPTY, opN = 0, opN_valid = 0, err = 0 and err_count = 0, immediately and regardless of clock.
REQ-027 Reset asserted mid-operation SHALL discard buffered words; the first transfer SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-028 Package demux_pkg SHALL hold the WIDTH default, NUM_CH = 3, ERR_MAX = 255 and the enum ch_state_t {CH_EMPTY, CH_FULL}.
REQ-029 The one-entry channel buffer SHALL be the sub-module demux_chan (load, data, ready in; state, data, valid out), instantiated three times.
REQ-030 Select legality decode, in_ready generation, err and err_count SHALL live in demux's top level.

Verification
REQ-031 Reset, then ip=0001 with sel=001 for one cycle -> op1=0001 and op1_valid=1 next cycle; op2_valid and op3_valid stay 0.
REQ-032 Back-to-back ip=0010 sel=010 then ip=0100 sel=010, with op2_ready held high -> op2 shows 0010 then 0100 on consecutive cycles; in_ready stays 1.
REQ-033 Channel 3 FULL with op3_ready=0, then offer sel=100 -> in_ready=0 and op3 is unchanged; raise op3_ready -> new word accepted the same cycle.
REQ-034 Offer sel=000 then sel=111 with in_valid=1 -> err pulses twice, err_count=2, and no opN_valid rises.
REQ-035 Apply 300 illegal transfers -> err_count=255 and held there.
REQ-036 Assert reset mid-stream with all channels FULL -> all opN_valid=0, opN=0 and err_count=0 with no clock edge; normal transfer resumes after release.
